// File: rtl/serial_sub_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial full subtractor: a - b - bin, LSB first, one bit per clock with a
// single registered borrow; result and final borrow are held until the next completion.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             done;
    logic [1:0]       fs;

    // Returns {borrow_out, difference_bit} of a one-bit full subtractor.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        return {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
    endfunction

    always_comb fs = full_sub(sa[0], sb[0], br);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            res   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        sa    <= bus.a;
                        sb    <= bus.b;
                        br    <= bus.bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Difference bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                    res <= WIDTH'({fs[0], res} >> 1);
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= fs[1];
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        diff  <= WIDTH'({fs[0], res} >> 1);
                        bout  <= fs[1];
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.diff = diff;
    assign bus.bout = bout;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: cycle-accurate timeline model on an 8-bit instance plus
// directed literal vectors, and an exhaustive sweep of a 4-bit instance.
module tb_serial_sub;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(8)) bus8 ();
    serial_sub_if #(.WIDTH(4)) bus4 ();

    serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted start yields done WIDTH edges later, idle one edge after.
    logic       m_busy, m_done, m_bout;
    logic [7:0] m_diff;
    logic [8:0] m_res;
    int         m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_bout = 1'b0; m_diff = '0; m_res = '0; m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                {m_bout, m_diff} = m_res;
            end else if (m_left < 0) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end
        end else if (bus8.start) begin
            m_busy = 1'b1;
            m_left = 8;
            m_res  = {1'b0, bus8.a} - {1'b0, bus8.b} - 9'(bus8.bin);
        end
    end

    always @(negedge clk) begin
        chk("busy8", 32'(bus8.busy), 32'(m_busy));
        chk("done8", 32'(bus8.done), 32'(m_done));
        chk("diff8", 32'(bus8.diff), 32'(m_diff));
        chk("bout8", 32'(bus8.bout), 32'(m_bout));
    end

    task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] ediff, input logic ebout);
        int lat;
        lat = -1;
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a = ~a; bus8.b = ~b; bus8.bin = ~bin;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus8.done) begin lat = n; break; end
        end
        chk({nm, "_latency"}, 32'(lat), 32'd8);
        chk({nm, "_diff"}, 32'(bus8.diff), 32'(ediff));
        chk({nm, "_bout"}, 32'(bus8.bout), 32'(ebout));
        @(negedge clk);
        chk({nm, "_done_width"}, 32'(bus8.done), 32'd0);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        int         lat;
        logic [4:0] exp5;
        lat  = -1;
        exp5 = 5'((32'(a) - 32'(b) - 32'(bin)) & 32'h1f);
        @(negedge clk);
        bus4.a = a; bus4.b = b; bus4.bin = bin; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus4.done) begin lat = n; break; end
        end
        chk("w4_latency", 32'(lat), 32'd4);
        chk($sformatf("w4_%0h_%0h_%0h", a, b, bin), 32'({bus4.bout, bus4.diff}), 32'(exp5));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int ndone, last, cyc;
        rst_n = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_done", 32'(bus8.done), 32'd0);
        chk("rst_diff", 32'(bus8.diff), 32'd0);
        chk("rst_bout", 32'(bus8.bout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op8("basic",  8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
        op8("under",  8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        op8("chain",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        op8("msb",    8'h80, 8'h00, 1'b1, 8'h7F, 1'b0);

        // Start held high with operands churning every cycle.
        ndone = 0; last = -1;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
        for (cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (bus8.done) begin
                if (last >= 0) chk("done_period", 32'(cyc - last), 32'd10);
                last = cyc;
                ndone++;
            end
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
        end
        chk("held_start_dones", 32'(ndone), 32'd4);
        bus8.start = 1'b0;
        repeat (15) @(negedge clk);

        // Abort a running operation with an asynchronous reset.
        bus8.a = 8'h9C; bus8.b = 8'h21; bus8.bin = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus8.busy), 32'd0);
        chk("midrst_done", 32'(bus8.done), 32'd0);
        chk("midrst_diff", 32'(bus8.diff), 32'd0);
        chk("midrst_bout", 32'(bus8.bout), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        op8("after_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++)
                    op4(4'(a), 4'(b), 1'(bi));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
